wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter sitting directly upstream of the register file's single write port. Merges the in-order pipeline writeback (ALU/load results from the MEM/WB boundary) with out-of-order completions from the long-latency unit (mul/div) through a small result FIFO. Drives the register file's `rd`, `regwrite`, `rd_data` from registered outputs and exports a pending-destination mask for upstream hazard detection.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `DEPTH`, 2, long-latency result FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `pipe_valid`  in  1  pipeline writeback beat present.
- `pipe_rd`  in  5  pipeline destination register.
- `pipe_data`  in  XLEN  pipeline result.
- `wb_stall`  out  1  pipeline beat not accepted this cycle; upstream holds `pipe_*` stable.
- `lu_valid`  in  1  long-latency result offered.
- `lu_rd`  in  5  long-latency destination.
- `lu_data`  in  XLEN  long-latency result.
- `lu_ready`  out  1  FIFO can accept; transfer on `lu_valid && lu_ready`.
- `rd`  out  5  register-file write address (registered).
- `regwrite`  out  1  register-file write enable (registered).
- `rd_data`  out  XLEN  register-file write data (registered).
- `pend_mask`  out  32  bit i set iff a FIFO entry targets xi; bit 0 always 0.

## Operation
- `count` = FIFO occupancy, 0..DEPTH.
- `wb_stall = (count == DEPTH)`, combinational from state.
- `lu_ready = (count < DEPTH) && !rst`.
- `pipe_take = pipe_valid && !wb_stall && (pipe_rd != 0)`.
- `pipe_valid` with `pipe_rd == 0` and `!wb_stall`: beat consumed, no write, slot free for FIFO.
- `pop = (count > 0) && !pipe_take`; pipeline has priority unless the FIFO is full.
- `lu_valid && lu_ready && lu_rd == 0`: handshake completes, result dropped, nothing enqueued.
- Output register next state: `pipe_take` → {1, pipe_rd, pipe_data}; else `pop` → {1, head.rd, head.data}; else `regwrite` ← 0, `rd`/`rd_data` hold.
- Simultaneous push and pop allowed; `count` unchanged; pushed entry goes behind the head.
- `pend_mask` = OR of one-hot(rd) over valid FIFO entries; registered state only, not the incoming beat or output register (the register file's write-bypass covers the output register).
- No WAW check: issue never dispatches an instruction whose rd matches an outstanding long-latency rd; the block does not enforce it.

## Timing
- Reset (`rst` high at posedge): `count`=0, FIFO pointers 0, `regwrite`=0, `rd`=0, `rd_data`=0. While `rst` is high: `wb_stall`=0, `lu_ready`=0, `pend_mask`=0. Reset mid-operation discards all FIFO contents.
- Latency: accepted pipeline beat → `regwrite` high exactly 1 cycle later; FIFO entry → written 1 cycle after the cycle it pops.
- Full FIFO: pipeline stalls for exactly 1 cycle per full event (head pops, `count` becomes DEPTH-1, no push possible since `lu_ready`=0).
- Empty FIFO with no pipeline beat: `regwrite`=0 next cycle.
- Pointers wrap modulo DEPTH; `count` uses `$clog2(DEPTH)+1` bits.

## Structure
- Shared package `riscvx_pkg`: `XLEN`, `REG_ADDR_W = 5`, `wb_entry_t` {rd[4:0], data[XLEN-1:0]}.
- One sub-module: `wb_fifo` (synchronous FIFO of `wb_entry_t`, push/pop/count/entry-valid vector for `pend_mask`). Arbitration and output register live in `wb_arbiter`.

## Test plan
- Reset: hold `rst` 2 cycles with `pipe_valid`=`lu_valid`=1 → `regwrite`=0, `lu_ready`=0, `pend_mask`=0, `count`=0 after release.
- Pipeline only: `pipe_rd`=5, `pipe_data`=0xDEADBEEF → next cycle `rd`=5, `regwrite`=1, `rd_data`=0xDEADBEEF; `wb_stall` never set.
- Priority: FIFO holds {rd=7, 0x11}; `pipe_rd`=3 for 3 cycles → x3 written 3 times, then x7=0x11 on the first idle cycle; `pend_mask`=0x80 until pop.
- Full stall: push {9,0xA},{10,0xB} while pipeline busy → `wb_stall`=1, `lu_ready`=0, `pend_mask`=0x600; next cycle x9=0xA written, stall released, held pipeline beat written the cycle after.
- x0 handling: `pipe_rd`=0 plus `lu_rd`=0 beats → no writes, no enqueue, `pend_mask` bit 0 stays 0.
- Simultaneous push/pop at `count`=1: `count` stays 1, entries retire in arrival order.

Source files
------------

// File: rtl/riscvx_pkg.sv
// Shared definitions for the writeback path.
//   XLEN       : datapath width
//   REG_ADDR_W : register-file address width
//   wb_entry_t : one pending writeback {rd, data}
package riscvx_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // One-hot decode of a register address, with x0 forced to zero because
  // x0 is never a real destination.
  function automatic logic [31:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [31:0] oh;
    oh     = 32'd1 << rd;
    oh[0]  = 1'b0;
    return oh;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding long-latency writeback results.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push         : enqueue push_entry (ignored when full)
//   push_entry   : entry to enqueue
//   pop          : dequeue head (ignored when empty)
//   head         : oldest entry
//   count        : occupancy, 0..DEPTH
//   entry_valid  : per-slot occupancy, used for the pending-destination mask
//   entries      : raw slot contents, meaningful where entry_valid is set
module wb_fifo
  import riscvx_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic [DEPTH-1:0] entry_valid,
  output wb_entry_t        entries [DEPTH]
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             full, empty, push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Slot valid bits mirror the pointer pair; a pop clears the head slot and
  // a push sets the tail slot. Both can happen in one cycle on different slots.
  always_comb begin
    valid_d = valid_q;
    if (pop_ok)  valid_d[rd_ptr_q] = 1'b0;
    if (push_ok) valid_d[wr_ptr_q] = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Storage carries no reset; slot contents are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head        = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign entry_valid = valid_q;
  assign entries     = mem_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter in front of the register file's single write port.
// Merges the in-order pipeline writeback with long-latency (mul/div) results
// buffered in a small FIFO. The pipeline wins unless the FIFO is full, in
// which case the pipeline stalls one cycle while the head drains.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   pipe_valid/pipe_rd/pipe_data    : pipeline writeback beat
//   wb_stall                        : beat not accepted this cycle (hold inputs)
//   lu_valid/lu_rd/lu_data          : long-latency result offer
//   lu_ready                        : FIFO accepts; transfer on lu_valid && lu_ready
//   rd/regwrite/rd_data             : registered register-file write port
//   pend_mask                       : destinations held in the FIFO (bit 0 always 0)
//
// Handshakes: pipe side is valid/stall - a beat with pipe_valid high and
// wb_stall low is consumed at the clock edge; otherwise upstream holds it.
// lu side is valid/ready - a transfer happens at the edge where both are high
// and is never retracted; an x0 destination completes the handshake but is
// dropped.
module wb_arbiter
  import riscvx_pkg::*;
#(
  parameter int XLEN  = riscvx_pkg::XLEN,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_valid,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  output logic            wb_stall,
  input  logic            lu_valid,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  output logic [4:0]      rd,
  output logic            regwrite,
  output logic [XLEN-1:0] rd_data,
  output logic [31:0]     pend_mask
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t        push_entry, head;
  wb_entry_t        entries [DEPTH];
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] entry_valid;
  logic             full, pipe_take, pop, push;

  logic [4:0]       rd_q, rd_d;
  logic             regwrite_q, regwrite_d;
  logic [XLEN-1:0]  rd_data_q, rd_data_d;
  logic [31:0]      pend_d;

  assign full      = (count == CNT_W'(DEPTH));
  assign wb_stall  = full && !rst;
  assign lu_ready  = !full && !rst;

  // An x0 pipeline beat is consumed without a write, leaving the port free
  // for the FIFO head in the same cycle.
  assign pipe_take = pipe_valid && !full && (pipe_rd != 5'd0);
  assign pop       = (count != '0) && !pipe_take;
  assign push      = lu_valid && lu_ready && (lu_rd != 5'd0);

  assign push_entry.rd   = lu_rd;
  assign push_entry.data = lu_data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head        (head),
    .count       (count),
    .entry_valid (entry_valid),
    .entries     (entries)
  );

  always_comb begin
    rd_d       = rd_q;
    rd_data_d  = rd_data_q;
    regwrite_d = 1'b0;
    if (pipe_take) begin
      regwrite_d = 1'b1;
      rd_d       = pipe_rd;
      rd_data_d  = pipe_data;
    end else if (pop) begin
      regwrite_d = 1'b1;
      rd_d       = head.rd;
      rd_data_d  = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd       = rd_q;
  assign regwrite = regwrite_q;
  assign rd_data  = rd_data_q;

  // Only FIFO-resident destinations are reported; the output register is
  // covered by the register file's write bypass.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pend_d = pend_d | rd_onehot(entries[i].rd);
    end
    if (rst) pend_d = '0;
  end

  assign pend_mask = pend_d;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk;
  logic            rst;
  logic            pipe_valid;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            wb_stall;
  logic            lu_valid;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            lu_ready;
  logic [4:0]      rd;
  logic            regwrite;
  logic [XLEN-1:0] rd_data;
  logic [31:0]     pend_mask;

  int checks   = 0;
  int failures = 0;

  wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .wb_stall   (wb_stall),
    .lu_valid   (lu_valid),
    .lu_rd      (lu_rd),
    .lu_data    (lu_data),
    .lu_ready   (lu_ready),
    .rd         (rd),
    .regwrite   (regwrite),
    .rd_data    (rd_data),
    .pend_mask  (pend_mask)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_pipe(input logic v, input logic [4:0] r, input logic [XLEN-1:0] d);
    pipe_valid = v;
    pipe_rd    = r;
    pipe_data  = d;
  endtask

  task automatic drive_lu(input logic v, input logic [4:0] r, input logic [XLEN-1:0] d);
    lu_valid = v;
    lu_rd    = r;
    lu_data  = d;
  endtask

  task automatic idle();
    drive_pipe(1'b0, 5'd0, '0);
    drive_lu(1'b0, 5'd0, '0);
  endtask

  // Write-port expectation; when exp_we is 0 only regwrite is compared.
  task automatic expect_wr(input string tag, input logic exp_we,
                           input logic [4:0] exp_rd, input logic [XLEN-1:0] exp_d);
    checks++;
    if (regwrite !== exp_we) begin
      failures++;
      $display("FAIL %s regwrite got=%0b exp=%0b", tag, regwrite, exp_we);
    end
    if (exp_we) begin
      checks++;
      if (rd !== exp_rd || rd_data !== exp_d) begin
        failures++;
        $display("FAIL %s write got=x%0d:%h exp=x%0d:%h", tag, rd, rd_data, exp_rd, exp_d);
      end
    end
  endtask

  task automatic expect_status(input string tag, input logic exp_stall,
                               input logic exp_ready, input logic [31:0] exp_pend);
    checks++;
    if (wb_stall !== exp_stall || lu_ready !== exp_ready || pend_mask !== exp_pend) begin
      failures++;
      $display("FAIL %s status got stall=%0b ready=%0b pend=%h exp stall=%0b ready=%0b pend=%h",
               tag, wb_stall, lu_ready, pend_mask, exp_stall, exp_ready, exp_pend);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_pipe(1'b1, 5'd5, 32'h1234_5678);
    drive_lu(1'b1, 5'd4, 32'h0000_0044);
    tick();
    tick();
    expect_status("reset_hold", 1'b0, 1'b0, 32'h0);
    checks++;
    if (regwrite !== 1'b0 || rd !== 5'd0 || rd_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs got we=%0b rd=%0d data=%h exp we=0 rd=0 data=0",
               regwrite, rd, rd_data);
    end
    rst = 1'b0;
    idle();
    #1;
    expect_status("reset_release", 1'b0, 1'b1, 32'h0);
    tick();
    expect_wr("reset_idle", 1'b0, 5'd0, '0);
    expect_status("reset_empty", 1'b0, 1'b1, 32'h0);
  endtask

  task automatic test_pipe_only();
    drive_pipe(1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    expect_status("pipe_pre", 1'b0, 1'b1, 32'h0);
    tick();
    idle();
    expect_wr("pipe_write", 1'b1, 5'd5, 32'hDEAD_BEEF);
    expect_status("pipe_post", 1'b0, 1'b1, 32'h0);
    tick();
    expect_wr("pipe_idle", 1'b0, 5'd0, '0);
    checks++;
    if (rd !== 5'd5 || rd_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL pipe_hold got=x%0d:%h exp=x5:deadbeef", rd, rd_data);
    end
  endtask

  task automatic test_priority();
    drive_pipe(1'b1, 5'd3, 32'h30);
    drive_lu(1'b1, 5'd7, 32'h11);
    tick();
    expect_wr("prio_x3_0", 1'b1, 5'd3, 32'h30);
    expect_status("prio_pend_0", 1'b0, 1'b1, 32'h80);
    drive_lu(1'b0, 5'd0, '0);
    drive_pipe(1'b1, 5'd3, 32'h31);
    tick();
    expect_wr("prio_x3_1", 1'b1, 5'd3, 32'h31);
    expect_status("prio_pend_1", 1'b0, 1'b1, 32'h80);
    drive_pipe(1'b1, 5'd3, 32'h32);
    tick();
    expect_wr("prio_x3_2", 1'b1, 5'd3, 32'h32);
    expect_status("prio_pend_2", 1'b0, 1'b1, 32'h80);
    idle();
    tick();
    expect_wr("prio_x7", 1'b1, 5'd7, 32'h11);
    expect_status("prio_drained", 1'b0, 1'b1, 32'h0);
    tick();
    expect_wr("prio_idle", 1'b0, 5'd0, '0);
  endtask

  task automatic test_full_stall();
    drive_pipe(1'b1, 5'd1, 32'h100);
    drive_lu(1'b1, 5'd9, 32'hA);
    tick();
    expect_wr("full_x1", 1'b1, 5'd1, 32'h100);
    expect_status("full_one", 1'b0, 1'b1, 32'h200);
    drive_pipe(1'b1, 5'd2, 32'h200);
    drive_lu(1'b1, 5'd10, 32'hB);
    tick();
    expect_wr("full_x2", 1'b1, 5'd2, 32'h200);
    drive_lu(1'b0, 5'd0, '0);
    drive_pipe(1'b1, 5'd4, 32'h400);
    #1;
    expect_status("full_stall", 1'b1, 1'b0, 32'h600);
    tick();
    expect_wr("full_x9", 1'b1, 5'd9, 32'hA);
    expect_status("full_release", 1'b0, 1'b1, 32'h400);
    tick();
    idle();
    expect_wr("full_held_x4", 1'b1, 5'd4, 32'h400);
    expect_status("full_after_held", 1'b0, 1'b1, 32'h400);
    tick();
    expect_wr("full_x10", 1'b1, 5'd10, 32'hB);
    expect_status("full_empty", 1'b0, 1'b1, 32'h0);
    tick();
    expect_wr("full_idle", 1'b0, 5'd0, '0);
  endtask

  task automatic test_x0();
    drive_pipe(1'b1, 5'd0, 32'hFFFF_FFFF);
    drive_lu(1'b1, 5'd0, 32'hEEEE_EEEE);
    #1;
    expect_status("x0_pre", 1'b0, 1'b1, 32'h0);
    tick();
    expect_wr("x0_nowrite_0", 1'b0, 5'd0, '0);
    expect_status("x0_noenq_0", 1'b0, 1'b1, 32'h0);
    tick();
    expect_wr("x0_nowrite_1", 1'b0, 5'd0, '0);
    expect_status("x0_noenq_1", 1'b0, 1'b1, 32'h0);
    // x0 pipeline beat leaves the port free for the FIFO head.
    drive_lu(1'b1, 5'd6, 32'h66);
    tick();
    expect_wr("x0_enq", 1'b0, 5'd0, '0);
    expect_status("x0_pend6", 1'b0, 1'b1, 32'h40);
    drive_lu(1'b0, 5'd0, '0);
    tick();
    idle();
    expect_wr("x0_pop_x6", 1'b1, 5'd6, 32'h66);
    expect_status("x0_drained", 1'b0, 1'b1, 32'h0);
    tick();
  endtask

  task automatic test_back_to_back();
    drive_pipe(1'b1, 5'd1, 32'h1);
    drive_lu(1'b1, 5'd11, 32'hB1);
    tick();
    expect_wr("b2b_x1", 1'b1, 5'd1, 32'h1);
    expect_status("b2b_cnt1", 1'b0, 1'b1, 32'h800);
    drive_pipe(1'b0, 5'd0, '0);
    drive_lu(1'b1, 5'd12, 32'hC2);
    tick();
    expect_wr("b2b_x11", 1'b1, 5'd11, 32'hB1);
    expect_status("b2b_swap1", 1'b0, 1'b1, 32'h1000);
    drive_lu(1'b1, 5'd13, 32'hD3);
    tick();
    expect_wr("b2b_x12", 1'b1, 5'd12, 32'hC2);
    expect_status("b2b_swap2", 1'b0, 1'b1, 32'h2000);
    idle();
    tick();
    expect_wr("b2b_x13", 1'b1, 5'd13, 32'hD3);
    expect_status("b2b_empty", 1'b0, 1'b1, 32'h0);
    tick();
    expect_wr("b2b_idle", 1'b0, 5'd0, '0);
  endtask

  task automatic test_reset_mid();
    drive_pipe(1'b1, 5'd2, 32'h22);
    drive_lu(1'b1, 5'd14, 32'hE4);
    tick();
    expect_status("mid_pend", 1'b0, 1'b1, 32'h4000);
    idle();
    rst = 1'b1;
    #1;
    expect_status("mid_rst_comb", 1'b0, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    expect_wr("mid_rst_out", 1'b0, 5'd0, '0);
    expect_status("mid_after", 1'b0, 1'b1, 32'h0);
    tick();
    expect_wr("mid_discarded", 1'b0, 5'd0, '0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_pipe_only();
    test_priority();
    test_full_stall();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
